verificador_jogadas_iniciais: RTL and testbench

Consumes the three pseudo-random board squares from the initial-move generator, buffers them, shows them one by one to the display stage, and checks the player's three answer moves against them in order. Directly downstream of the initial-move generator: drives its `novaJogada` strobe and `numJogada` select, and samples its `linha`/`coluna` outputs. Reports hit or miss to the game control unit.

---
 rtl/verificador_jogadas_iniciais.sv | 164 ++++++++++++++++
 tb/tb_verificador_jogadas_iniciais.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/verificador_jogadas_iniciais.sv
// Buffers the generator's initial moves, displays them one at a time and checks the player's
// answers in order. Outputs are registered: novaJogada/numJogada track the next state, the rest
// follow the current state with one cycle of lag.
module verificador_jogadas_iniciais #(
    parameter int unsigned N_JOGADAS = 3,
    parameter int unsigned T_EXIBE   = 50
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [2:0] linha_gerada,
    input  logic [2:0] coluna_gerada,
    input  logic       jogada_feita,
    input  logic [2:0] linha_jogador,
    input  logic [2:0] coluna_jogador,
    output logic       novaJogada,
    output logic [1:0] numJogada,
    output logic       exibe,
    output logic [2:0] linha_exibe,
    output logic [2:0] coluna_exibe,
    output logic       aguardando,
    output logic       acertou,
    output logic       errou
);

    localparam int unsigned TW = (T_EXIBE > 1) ? $clog2(T_EXIBE) : 1;
    localparam logic [1:0]    K_ULT = 2'(N_JOGADAS - 1);
    localparam logic [TW-1:0] T_ULT = TW'(T_EXIBE - 1);

    typedef enum logic [3:0] {
        StOcioso, StGera, StAssenta, StCaptura, StExibe,
        StAguarda, StCompara, StFimOk, StFimErro
    } estado_t;

    estado_t       estado_q, estado_d;
    logic [1:0]    k_q, k_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [5:0]    buf_q [4];
    logic [5:0]    jog_q;
    logic          buf_we, jog_we;

    logic       nova_q, exibe_q, aguardando_q, acertou_q, errou_q;
    logic [1:0] num_q;
    logic [2:0] linha_exibe_q, coluna_exibe_q;

    always_comb begin
        estado_d = estado_q;
        k_d      = k_q;
        timer_d  = timer_q;
        buf_we   = 1'b0;
        jog_we   = 1'b0;
        case (estado_q)
            StOcioso: begin
                if (iniciar) estado_d = StGera;
            end
            StGera: estado_d = StAssenta;
            StAssenta: begin
                k_d      = 2'd0;
                estado_d = StCaptura;
            end
            StCaptura: begin
                buf_we = 1'b1;
                if (k_q == K_ULT) begin
                    k_d      = 2'd0;
                    timer_d  = '0;
                    estado_d = StExibe;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            StExibe: begin
                if (timer_q == T_ULT) begin
                    timer_d = '0;
                    if (k_q == K_ULT) begin
                        k_d      = 2'd0;
                        estado_d = StAguarda;
                    end else begin
                        k_d = k_q + 2'd1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StAguarda: begin
                if (jogada_feita) begin
                    jog_we   = 1'b1;
                    estado_d = StCompara;
                end
            end
            StCompara: begin
                if (jog_q != buf_q[k_q]) begin
                    estado_d = StFimErro;
                end else if (k_q == K_ULT) begin
                    estado_d = StFimOk;
                end else begin
                    k_d      = k_q + 2'd1;
                    estado_d = StAguarda;
                end
            end
            StFimOk, StFimErro: begin
                k_d      = 2'd0;
                estado_d = StOcioso;
            end
            default: estado_d = StOcioso;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= StOcioso;
            k_q      <= 2'd0;
            timer_q  <= '0;
            jog_q    <= 6'd0;
            for (int i = 0; i < 4; i++) buf_q[i] <= 6'd0;
        end else begin
            estado_q <= estado_d;
            k_q      <= k_d;
            timer_q  <= timer_d;
            if (buf_we) buf_q[k_q] <= {linha_gerada, coluna_gerada};
            if (jog_we) jog_q <= {linha_jogador, coluna_jogador};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            nova_q         <= 1'b0;
            num_q          <= 2'd0;
            exibe_q        <= 1'b0;
            linha_exibe_q  <= 3'd0;
            coluna_exibe_q <= 3'd0;
            aguardando_q   <= 1'b0;
            acertou_q      <= 1'b0;
            errou_q        <= 1'b0;
        end else begin
            nova_q       <= (estado_d == StGera);
            // numJogada must equal k while capturing so the write lands in the matching entry
            num_q        <= (estado_d == StCaptura) ? k_d : 2'd0;
            exibe_q      <= (estado_q == StExibe);
            aguardando_q <= (estado_q == StAguarda);
            if (estado_q == StExibe) begin
                {linha_exibe_q, coluna_exibe_q} <= buf_q[k_q];
            end else begin
                {linha_exibe_q, coluna_exibe_q} <= 6'd0;
            end
            if (estado_q == StOcioso && iniciar) begin
                acertou_q <= 1'b0;
                errou_q   <= 1'b0;
            end else begin
                if (estado_q == StFimOk)   acertou_q <= 1'b1;
                if (estado_q == StFimErro) errou_q   <= 1'b1;
            end
        end
    end

    assign novaJogada   = nova_q;
    assign numJogada    = num_q;
    assign exibe        = exibe_q;
    assign linha_exibe  = linha_exibe_q;
    assign coluna_exibe = coluna_exibe_q;
    assign aguardando   = aguardando_q;
    assign acertou      = acertou_q;
    assign errou        = errou_q;

endmodule

// File: tb/tb_verificador_jogadas_iniciais.sv
// Scoreboard bench: expected display squares and round results are queued as stimulus is driven
// and popped by a negedge monitor; a second instance covers N_JOGADAS=1, T_EXIBE=1.
module tb_verificador_jogadas_iniciais;

    localparam int N = 3;
    localparam int T = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       iniciar, jogada_feita;
    logic [2:0] linha_gerada, coluna_gerada, linha_jogador, coluna_jogador;
    logic       novaJogada, exibe, aguardando, acertou, errou;
    logic [1:0] numJogada;
    logic [2:0] linha_exibe, coluna_exibe;

    logic       e_iniciar, e_jogada;
    logic [2:0] e_linha_g, e_coluna_g, e_linha_j, e_coluna_j;
    logic       e_nova, e_exibe, e_aguardando, e_acertou, e_errou;
    logic [1:0] e_num;
    logic [2:0] e_linha_x, e_coluna_x;

    logic [5:0] gen_tab [4];
    logic [5:0] mov_tab [3];
    logic [5:0] exp_disp [$];
    logic [1:0] res_q [$];

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int nova_total = 0;
    int nova_cyc = 0;
    int disp_start = 0;

    always #5 clk = ~clk;

    verificador_jogadas_iniciais #(.N_JOGADAS(N), .T_EXIBE(T)) u_dut (
        .clock(clk), .reset(reset), .iniciar(iniciar),
        .linha_gerada(linha_gerada), .coluna_gerada(coluna_gerada),
        .jogada_feita(jogada_feita), .linha_jogador(linha_jogador),
        .coluna_jogador(coluna_jogador), .novaJogada(novaJogada), .numJogada(numJogada),
        .exibe(exibe), .linha_exibe(linha_exibe), .coluna_exibe(coluna_exibe),
        .aguardando(aguardando), .acertou(acertou), .errou(errou)
    );

    verificador_jogadas_iniciais #(.N_JOGADAS(1), .T_EXIBE(1)) u_edge (
        .clock(clk), .reset(reset), .iniciar(e_iniciar),
        .linha_gerada(e_linha_g), .coluna_gerada(e_coluna_g),
        .jogada_feita(e_jogada), .linha_jogador(e_linha_j),
        .coluna_jogador(e_coluna_j), .novaJogada(e_nova), .numJogada(e_num),
        .exibe(e_exibe), .linha_exibe(e_linha_x), .coluna_exibe(e_coluna_x),
        .aguardando(e_aguardando), .acertou(e_acertou), .errou(e_errou)
    );

    // Generator models: combinational lookup on the select
    assign {linha_gerada, coluna_gerada} = gen_tab[numJogada];
    assign e_linha_g  = (e_num == 2'd0) ? 3'd6 : 3'd7;
    assign e_coluna_g = 3'd1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_aguardando();
        int n = 0;
        while (!aguardando && n < 100) begin
            tick();
            n++;
        end
        check_eq("aguardando_timeout", 32'(aguardando), 32'd1);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: display scoreboard, display length, novaJogada pulses, result scoreboard
    initial begin
        int   run = 0;
        logic ex_prev = 1'b0;
        logic [1:0] flag_prev = 2'b00;
        forever begin
            @(negedge clk);
            if (reset) begin
                run = 0;
                ex_prev = 1'b0;
                flag_prev = 2'b00;
            end else begin
                if (novaJogada) begin
                    nova_total++;
                    nova_cyc = cyc;
                end
                if (exibe) begin
                    if (!ex_prev) disp_start = cyc;
                    run++;
                    check_eq("disp_q_nonempty", 32'(exp_disp.size() != 0), 32'd1);
                    if (exp_disp.size() != 0)
                        check_eq("disp_square", 32'({linha_exibe, coluna_exibe}),
                                 32'(exp_disp.pop_front()));
                end else if (ex_prev) begin
                    check_eq("disp_len", 32'(run), 32'(N * T));
                    check_eq("aguard_after_disp", 32'(aguardando), 32'd1);
                    run = 0;
                end
                ex_prev = exibe;
                if ({acertou, errou} != 2'b00 && flag_prev == 2'b00) begin
                    check_eq("res_q_nonempty", 32'(res_q.size() != 0), 32'd1);
                    if (res_q.size() != 0)
                        check_eq("result", 32'({acertou, errou}), 32'(res_q.pop_front()));
                end
                flag_prev = {acertou, errou};
            end
        end
    end

    task automatic start_round(output int t0);
        for (int i = 0; i < N; i++)
            for (int t = 0; t < T; t++) exp_disp.push_back(gen_tab[i]);
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        t0 = cyc;
        check_eq("flags_cleared", 32'({acertou, errou}), 32'd0);
    endtask

    task automatic run_round(input bit disturb, input int bad_idx);
        int t0;
        int nova0;
        int deciding;
        logic [1:0] exp_flags;
        nova0 = nova_total;
        start_round(t0);
        if (disturb) begin
            tick(); tick(); tick();
            {linha_jogador, coluna_jogador} = 6'o77;
            jogada_feita = 1'b1;            // sampled during CAPTURA
            tick();
            jogada_feita = 1'b0;
            tick(); tick();
            iniciar = 1'b1;                 // both sampled during EXIBE
            jogada_feita = 1'b1;
            tick();
            iniciar = 1'b0;
            jogada_feita = 1'b0;
        end
        wait_aguardando();
        check_eq("nova_count", 32'(nova_total - nova0), 32'd1);
        check_eq("nova_cycle", 32'(nova_cyc - t0), 32'd0);
        check_eq("disp_start", 32'(disp_start - t0), 32'(N + 3));
        deciding  = (bad_idx < 0) ? N - 1 : bad_idx;
        exp_flags = (bad_idx < 0) ? 2'b10 : 2'b01;
        for (int i = 0; i < N; i++) begin
            {linha_jogador, coluna_jogador} = mov_tab[i];
            jogada_feita = 1'b1;
            if (i == deciding) res_q.push_back(exp_flags);
            tick();
            jogada_feita = 1'b0;
            if (i <= deciding) begin
                tick();
                check_eq("flags_j1", 32'({acertou, errou}), 32'd0);
                tick();
                if (i == deciding) begin
                    check_eq("flags_j2", 32'({acertou, errou}), 32'(exp_flags));
                end else begin
                    check_eq("flags_mid", 32'({acertou, errou}), 32'd0);
                    wait_aguardando();
                end
            end
        end
        repeat (5) tick();
        check_eq("flags_held", 32'({acertou, errou}), 32'(exp_flags));
        check_eq("idle_quiet", 32'({exibe, aguardando, novaJogada, numJogada}), 32'd0);
        check_eq("no_extra_nova", 32'(nova_total - nova0), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int e_cnt;
        int e_first;
        logic e_num_seen;
        reset = 1'b1;
        iniciar = 1'b0; jogada_feita = 1'b0;
        linha_jogador = 3'd0; coluna_jogador = 3'd0;
        e_iniciar = 1'b0; e_jogada = 1'b0; e_linha_j = 3'd0; e_coluna_j = 3'd0;
        for (int i = 0; i < 4; i++) gen_tab[i] = 6'd0;
        tick(); tick();
        check_eq("rst_outputs", 32'({novaJogada, numJogada, exibe, linha_exibe, coluna_exibe,
                                     aguardando, acertou, errou}), 32'd0);
        check_eq("rst_edge_outputs", 32'({e_nova, e_num, e_exibe, e_linha_x, e_coluna_x,
                                          e_aguardando, e_acertou, e_errou}), 32'd0);
        #2 reset = 1'b0;
        tick();

        // Round A: correct answers, with ignored iniciar/jogada_feita injected
        gen_tab[0] = {3'd1, 3'd2}; gen_tab[1] = {3'd3, 3'd4}; gen_tab[2] = {3'd5, 3'd6};
        mov_tab[0] = {3'd1, 3'd2}; mov_tab[1] = {3'd3, 3'd4}; mov_tab[2] = {3'd5, 3'd6};
        run_round(1'b1, -1);

        // Round B: wrong second move, third strobe ignored
        mov_tab[1] = {3'd3, 3'd5};
        run_round(1'b0, 1);

        // Asynchronous reset in the middle of the display
        start_round(t0);
        repeat (8) tick();
        check_eq("pre_rst_exibe", 32'(exibe), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_eq("rst_async", 32'({novaJogada, numJogada, exibe, linha_exibe, coluna_exibe,
                                   aguardando, acertou, errou}), 32'd0);
        tick(); tick();
        exp_disp.delete();
        #2 reset = 1'b0;
        tick();

        // Round C: repeated (0,0) squares
        for (int i = 0; i < 3; i++) begin
            gen_tab[i] = 6'd0;
            mov_tab[i] = 6'd0;
        end
        run_round(1'b0, -1);

        // Single-move, single-cycle display instance
        e_iniciar = 1'b1;
        tick();
        e_iniciar = 1'b0;
        t0 = cyc;
        e_cnt = 0; e_first = 0; e_num_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (e_num != 2'd0) e_num_seen = 1'b1;
            if (e_exibe) begin
                e_cnt++;
                e_first = cyc;
                check_eq("edge_square", 32'({e_linha_x, e_coluna_x}), 32'({3'd6, 3'd1}));
            end
        end
        check_eq("edge_num_zero", 32'(e_num_seen), 32'd0);
        check_eq("edge_exibe_len", 32'(e_cnt), 32'd1);
        check_eq("edge_exibe_start", 32'(e_first - t0), 32'd4);
        check_eq("edge_aguardando", 32'(e_aguardando), 32'd1);
        {e_linha_j, e_coluna_j} = {3'd6, 3'd1};
        e_jogada = 1'b1;
        tick();
        e_jogada = 1'b0;
        tick();
        check_eq("edge_flags_j1", 32'({e_acertou, e_errou}), 32'd0);
        tick();
        check_eq("edge_flags_j2", 32'({e_acertou, e_errou}), 32'({1'b1, 1'b0}));

        repeat (3) tick();
        check_eq("disp_q_drained", 32'(exp_disp.size()), 32'd0);
        check_eq("res_q_drained", 32'(res_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
